sensor_scheduler: RTL

Sequencer for the on-board sensor path. Periodically triggers the DHT11 reader through a start/busy/done/error handshake, applies timeout and bounded retry, and latches the last good humidity/temperature frame. Also time-multiplexes the single 7-segment value bus between temperature, humidity and the IR event count. Sits in `top` between the DHT11 reader, the IR counter and the display driver.

---
 rtl/sensor_scheduler.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
//
// Sequencer for the on-board sensor path. Periodically starts a DHT11 read
// through a start/busy/done/error handshake, applies a response timeout and a
// bounded number of retries per period, and latches the last good
// humidity/temperature frame. Independently rotates the single 7-segment value
// bus between temperature, humidity and (optionally) the IR event count.
//
// All *_MS timers advance on a 1 ms tick derived from CLK_HZ.
//
// Compile-time option:
//   SENSOR_SCHED_IR_DISPLAY_EN  defined   -> display rotates temp, hum, IR count
//                               undefined -> display rotates temp, hum only;
//                                            ir_count is unused
//
// Parameters:
//   CLK_HZ      system clock frequency (integer multiple of 1000)
//   PERIOD_MS   interval between read attempts (also power-up delay)
//   TIMEOUT_MS  maximum wait for dht_done/dht_err after dht_start
//   RETRY_MS    gap before a retry after a failed attempt
//   MAX_RETRY   retries per period after the first attempt fails
//   SHOW_MS     dwell time of each display source
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   dht_start   out  one-cycle pulse starting a DHT11 transaction
//   dht_busy    in   reader transaction in progress
//   dht_done    in   one-cycle pulse, frame valid and checksum OK
//   dht_err     in   one-cycle pulse, checksum or protocol error
//   dht_hum     in   integer humidity, sampled on dht_done
//   dht_temp    in   integer temperature, sampled on dht_done
//   ir_count    in   IR event count (binary)
//   disp_value  out  binary value for the display driver
//   disp_sel    out  displayed source: 0 temp, 1 humidity, 2 IR count
//   valid_data  out  high once a good frame is latched, cleared on fault
//   fault       out  sticky until the next good frame; retries exhausted
// -----------------------------------------------------------------------------
module sensor_scheduler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int TIMEOUT_MS = 30,
    parameter int RETRY_MS   = 100,
    parameter int MAX_RETRY  = 3,
    parameter int SHOW_MS    = 3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        dht_start,
    input  logic        dht_busy,
    input  logic        dht_done,
    input  logic        dht_err,
    input  logic [7:0]  dht_hum,
    input  logic [7:0]  dht_temp,
    input  logic [15:0] ir_count,
    output logic [15:0] disp_value,
    output logic [1:0]  disp_sel,
    output logic        valid_data,
    output logic        fault
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // One shared millisecond timer serves all FSM waits; it only has to reach
    // the largest of the three intervals and then saturates.
    localparam int T_MAX0 = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
    localparam int T_MAX  = (T_MAX0 > RETRY_MS) ? T_MAX0 : RETRY_MS;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam int SW = (SHOW_MS > 1) ? $clog2(SHOW_MS) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef SENSOR_SCHED_IR_DISPLAY_EN
    localparam logic [1:0] LAST_SRC = 2'd2;
`else
    localparam logic [1:0] LAST_SRC = 2'd1;
`endif

    typedef enum logic [1:0] {
        WAIT_PERIOD = 2'd0,
        START       = 2'd1,
        WAIT_RESP   = 2'd2,
        BACKOFF     = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]   presc;
    logic            tick;

    logic [TW-1:0]   ms_cnt;
    logic [RW-1:0]   retry_cnt;

    logic            period_up;
    logic            timeout_up;
    logic            backoff_up;
    logic            resp_ok;
    logic            resp_fail;
    logic            retry_left;

    logic [7:0]      temp_lat;
    logic [7:0]      hum_lat;

    logic [SW-1:0]   show_cnt;
    logic [1:0]      rot_sel_p0;
    logic [15:0]     src_value_p0;

    // ---------------------------------------------------------------------
    // Millisecond tick
    // ---------------------------------------------------------------------
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    assign period_up  = (ms_cnt >= TW'(PERIOD_MS));
    assign timeout_up = (ms_cnt >= TW'(TIMEOUT_MS));
    assign backoff_up = (ms_cnt >= TW'(RETRY_MS));

    // A simultaneous done/err is an error: the frame cannot be trusted.
    assign resp_ok    = dht_done & ~dht_err;
    assign resp_fail  = dht_err | timeout_up;
    assign retry_left = (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_PERIOD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_PERIOD: begin
                // Never start a new period over a transaction still running.
                if (period_up && !dht_busy) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_ok) begin
                    state_next = WAIT_PERIOD;
                end else if (resp_fail) begin
                    state_next = retry_left ? BACKOFF : WAIT_PERIOD;
                end
            end
            BACKOFF: begin
                if (backoff_up) begin
                    state_next = START;
                end
            end
            default: begin
                state_next = WAIT_PERIOD;
            end
        endcase
    end

    always_comb begin
        dht_start = 1'b0;
        if (state == START) begin
            dht_start = 1'b1;
        end
    end

    // Timer restarts on every state change, so each state measures its own
    // interval from entry (period, timeout and backoff alike).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_cnt <= '0;
        end else if (state_next != state) begin
            ms_cnt <= '0;
        end else if (tick && (ms_cnt != TW'(T_MAX))) begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Frame latch, retry count and status flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt  <= '0;
            valid_data <= 1'b0;
            fault      <= 1'b0;
            temp_lat   <= '0;
            hum_lat    <= '0;
        end else if (state == WAIT_RESP) begin
            if (resp_ok) begin
                temp_lat   <= dht_temp;
                hum_lat    <= dht_hum;
                valid_data <= 1'b1;
                fault      <= 1'b0;
                retry_cnt  <= '0;
            end else if (resp_fail) begin
                if (retry_left) begin
                    retry_cnt <= retry_cnt + 1'b1;
                end else begin
                    fault      <= 1'b1;
                    valid_data <= 1'b0;
                    retry_cnt  <= '0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Display rotation (stage p0: source select and value)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            show_cnt   <= '0;
            rot_sel_p0 <= 2'd0;
        end else if (tick) begin
            if (show_cnt == SW'(SHOW_MS - 1)) begin
                show_cnt   <= '0;
                rot_sel_p0 <= (rot_sel_p0 == LAST_SRC) ? 2'd0 : rot_sel_p0 + 2'd1;
            end else begin
                show_cnt <= show_cnt + 1'b1;
            end
        end
    end

`ifndef SENSOR_SCHED_IR_DISPLAY_EN
    logic unused_ir;
    assign unused_ir = ^ir_count;
`endif

    always_comb begin
        src_value_p0 = 16'd0;
        case (rot_sel_p0)
            2'd0: src_value_p0 = {8'd0, temp_lat};
            2'd1: src_value_p0 = {8'd0, hum_lat};
`ifdef SENSOR_SCHED_IR_DISPLAY_EN
            2'd2: src_value_p0 = ir_count;
`endif
            default: src_value_p0 = 16'd0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Stage p1: registered display outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_sel   <= 2'd0;
            disp_value <= 16'd0;
        end else begin
            disp_sel   <= rot_sel_p0;
            disp_value <= src_value_p0;
        end
    end

endmodule
